serial_add_sequencer: RTL

Bit-serial add/subtract sequencer for the 32-bit MIPS datapath. It owns no adder logic: it drives one external full-adder cell (operand bits and carry in), one bit per cycle LSB-first. It captures the cell's sum and carry back into registers, then presents a WIDTH-bit result with MIPS-style carry, overflow and zero flags. It sits directly upstream of the full-adder cell and downstream of the operand/ALU-control logic.

---
 rtl/serial_add_sequencer.sv | 85 ++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: drives an external full-adder cell LSB-first to form a WIDTH-bit add/sub with MIPS flags
module serial_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fa_d1,
  output logic             fa_d2,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic [WIDTH-1:0] fin;
  assign fin    = {fa_sum, acc};
  assign fa_d1  = (state == RUN) & a_sh[0];
  assign fa_d2  = (state == RUN) & b_sh[0];
  assign fa_cin = (state == RUN) & carry;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          acc   <= fin[WIDTH-1:1];
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // carry still holds the carry into the MSB on this last bit
            result    <= fin;
            carry_out <= fa_cout;
            overflow  <= carry ^ fa_cout;
            zero      <= ~|fin;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
